hazard_scoreboard: RTL

Parametrised load-use and long-latency hazard unit for the pipelined MIPS core, sitting beside the ID stage. It generalises single-cycle load-use detection into a per-register countdown scoreboard. Loads, multiply/divide and any future multi-cycle unit each have their own configurable result latency. It drives the same Stall_IF / Stall_ID / Flush_EX controls into the pipeline registers. It also adds a structural stall for a busy multiply/divide unit, kill/hold handling and a saturating stall counter.

---
 rtl/mips_pkg.sv | 14 +
 rtl/sb_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: instruction class and
// scoreboard countdown width.
package mips_pkg;

  typedef enum logic [1:0] {
    CLASS_ALU    = 2'd0,
    CLASS_LOAD   = 2'd1,
    CLASS_MULDIV = 2'd2,
    CLASS_RSVD   = 2'd3
  } class_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard countdown: decrements while enabled,
// optionally raised to a new latency (max rule).
import mips_pkg::*;

module sb_counter (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_lat,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_dec;
  logic [CNT_W-1:0] w_nxt;

  // WAW keeps whichever pending result lands later
  always_comb begin
    w_dec = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_nxt = w_dec;
    if (i_load && (i_lat > w_dec))
      w_nxt = i_lat;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard unit beside ID: RAW and
// busy mult/div stalls, kill/hold, saturating stall count.
import mips_pkg::*;

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  Rs_ID,
  input  logic [REG_W-1:0]  Rt_ID,
  input  logic              RsUsed_ID,
  input  logic              RtUsed_ID,
  input  logic [REG_W-1:0]  Dest_ID,
  input  logic              RegWrite_ID,
  input  logic [1:0]        Class_ID,
  input  logic              Kill_ID,
  input  logic              Hold,
  output logic              Stall_IF,
  output logic              Stall_ID,
  output logic              Flush_EX,
  output logic [STAT_W-1:0] StallCount
);

  localparam logic [CNT_W-1:0] LD_L = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MD_L = CNT_W'(MD_LAT);

  class_e            w_cls;
  logic [CNT_W-1:0]  w_cnt [NUM_REGS];
  logic [CNT_W-1:0]  w_md;
  logic [CNT_W-1:0]  w_lat;
  logic              w_rs_hit;
  logic              w_rt_hit;
  logic              w_struct;
  logic              w_hz;
  logic              w_issue;
  logic              w_wr;
  logic [STAT_W-1:0] r_stall;

  assign w_cls = class_e'(Class_ID);

  always_comb begin
    w_lat = '0;
    unique case (w_cls)
      CLASS_LOAD:   w_lat = LD_L;
      CLASS_MULDIV: w_lat = MD_L;
      default:      w_lat = '0;
    endcase
  end

  assign w_rs_hit = RsUsed_ID && (Rs_ID != '0)
                 && (w_cnt[Rs_ID] != '0);
  assign w_rt_hit = RtUsed_ID && (Rt_ID != '0)
                 && (w_cnt[Rt_ID] != '0);
  assign w_struct = (w_cls == CLASS_MULDIV)
                 && (w_md != '0);

  // Hold deliberately stays out of the hazard path
  assign w_hz    = (w_rs_hit | w_rt_hit | w_struct)
                 & ~Kill_ID;
  assign w_issue = ~w_hz & ~Kill_ID & ~Hold;
  assign w_wr    = w_issue & RegWrite_ID
                 & (Dest_ID != '0);

  assign w_cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_counter u_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_en   (~Hold),
      .i_load (w_wr && (Dest_ID == REG_W'(r))),
      .i_lat  (w_lat),
      .o_cnt  (w_cnt[r])
    );
  end

  sb_counter u_md (
    .clk    (clk),
    .reset  (reset),
    .i_en   (~Hold),
    .i_load (w_issue && (w_cls == CLASS_MULDIV)),
    .i_lat  (MD_L),
    .o_cnt  (w_md)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_stall <= '0;
    else if (w_hz && !Hold && (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end

  assign Stall_IF   = w_hz;
  assign Stall_ID   = w_hz;
  assign Flush_EX   = w_hz;
  assign StallCount = r_stall;

endmodule
